// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the multicycle datapath: widths, reset vector,
// NOP encoding, base opcodes and the fetch FSM state encoding.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/pc_register.sv
// Program counter with +4 incrementer, branch-target mux (target forced word-aligned)
// and a registered one-cycle pulse when a misaligned target is written.
module pc_register
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;

    // Incrementer wraps naturally at 2^XLEN.
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_pc_next  = pc_src ? {pc_target[XLEN-1:2], 2'b00} : w_pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            if (pc_write) begin
                r_pc <= w_pc_next;
            end
            r_misalign <= pc_write & pc_src & (|pc_target[1:0]);
        end
    end

    assign pc           = r_pc;
    assign misalign_err = r_misalign;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns PC and IR, runs a req/ack fetch with a watchdog,
// and exposes the IR decode fields consumed by the control unit.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic                      PCWrite,
    input  logic                      PCSrc,
    input  logic [XLEN-1:0]           pc_target,
    instr_fetch_unit_if.master        mem,
    output logic [XLEN-1:0]           Instr,
    output logic [6:0]                Opcode,
    output logic [2:0]                Funct3,
    output logic [6:0]                Funct7,
    output logic [XLEN-1:0]           PC,
    output logic [XLEN-1:0]           OldPC,
    output logic                      instr_valid,
    output logic                      fetch_busy,
    output logic                      fetch_err,
    output logic                      misalign_err
);

    localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_old_pc;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_mem_req;
    logic            r_instr_valid;
    logic            r_fetch_err;
    logic [WD_W-1:0] r_wdog;
    logic [XLEN-1:0] w_pc;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (PCWrite),
        .pc_src       (PCSrc),
        .pc_target    (pc_target),
        .pc           (w_pc),
        .misalign_err (misalign_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ir          <= XLEN'(NOP_INSTR);
            r_old_pc      <= RESET_PC;
            r_mem_addr    <= '0;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_fetch_err <= 1'b0;
            if (r_state == IDLE) begin
                // w_pc is the pre-update PC even if PCWrite is asserted this cycle.
                if (fetch_req) begin
                    r_state       <= FETCH;
                    r_mem_addr    <= w_pc;
                    r_mem_req     <= 1'b1;
                    r_instr_valid <= 1'b0;
                    r_wdog        <= '0;
                end
            end else begin
                if (mem.mem_ack) begin
                    r_state       <= IDLE;
                    r_ir          <= mem.mem_rdata;
                    r_old_pc      <= r_mem_addr;
                    r_instr_valid <= 1'b1;
                    r_mem_req     <= 1'b0;
                end else if (r_wdog == WD_MAX) begin
                    r_state     <= IDLE;
                    r_mem_req   <= 1'b0;
                    r_fetch_err <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;

    assign Instr       = r_ir;
    assign Opcode      = r_ir[6:0];
    assign Funct3      = r_ir[14:12];
    assign Funct7      = r_ir[31:25];
    assign PC          = w_pc;
    assign OldPC       = r_old_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_busy  = (r_state == FETCH);
    assign fetch_err   = r_fetch_err;

endmodule
